// File: rtl/pkg_sched_pkg.sv
// ============================================================================
// Module  : pkg_sched_pkg
// Brief   : Shared sizes, FSM encodings and fx register map for pkg_sched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pkg_sched_pkg;

    localparam int         NCH  = 8;
    localparam int         DW   = 16;
    localparam int         CW   = 3;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [3:0] c_reg_mask   = 4'h0;
    localparam logic [3:0] c_reg_ovf    = 4'h1;
    localparam logic [3:0] c_reg_pend   = 4'h2;
    localparam logic [3:0] c_reg_cnt_lo = 4'h3;
    localparam logic [3:0] c_reg_cnt_hi = 4'h4;
    localparam logic [3:0] c_reg_state  = 4'h5;

    function automatic logic [DW-1:0] make_hdr(input logic [4:0] seq,
                                               input logic [CW-1:0] ch);
        return {SYNC, seq, ch};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkg_sched_rr_arb8.sv
// ============================================================================
// Module  : rr_arb8
// Brief   : Combinational round-robin pick of the first request at/after rr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb8
    import pkg_sched_pkg::*;
(
    input  logic [NCH-1:0] i_req,
    input  logic [CW-1:0]  i_rr,
    output logic           o_gnt_vld,
    output logic [CW-1:0]  o_gnt_idx
);

    logic [CW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest hit is kept.
    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_idx = i_rr;
        w_idx     = i_rr;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_idx = i_rr + CW'(i);
            if (i_req[w_idx]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pkg_sched.sv
// ============================================================================
// Module  : pkg_sched
// Brief   : Round-robin packetiser of eight channel samples onto one pkg stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pkg_sched
    import pkg_sched_pkg::*;
(
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic [NCH-1:0]    ch_vld,
    output logic [DW-1:0]     pkg_d,
    output logic              pkg_vld,
    input  logic              pkg_rdy,
    output logic              pkg_done,
    input  logic [21:0]       fx_waddr,
    input  logic              fx_wr,
    input  logic [7:0]        fx_data,
    input  logic [21:0]       fx_raddr,
    input  logic              fx_rd,
    output logic [7:0]        fx_q,
    input  logic [5:0]        dev_id
);

    logic [NCH-1:0][DW-1:0] r_slot;
    logic [NCH-1:0]         r_pend;
    logic [NCH-1:0]         r_mask;
    logic [NCH-1:0]         r_ovf;
    logic [CW-1:0]          r_rr;
    logic [4:0]             r_seq;
    logic [15:0]            r_pkt_cnt;
    logic [DW-1:0]          r_data;
    state_t                 r_state;

    logic [NCH-1:0]         w_cap;
    logic [NCH-1:0]         w_gnt_oh;
    logic [NCH-1:0]         w_pend_nxt;
    logic [NCH-1:0]         w_ovf_nxt;
    logic                   w_gnt_vld;
    logic [CW-1:0]          w_gnt_idx;
    logic                   w_grant;
    logic                   w_wr_hit;
    logic                   w_rd_hit;
    logic                   w_mask_wr;
    logic                   w_ovf_wr;
    logic [7:0]             w_rd_val;
    logic                   w_unused;

    assign w_unused = ^{fx_waddr[15:4], fx_raddr[15:4]};

    assign w_cap     = ch_vld & r_mask;
    assign w_wr_hit  = fx_wr && (fx_waddr[21:16] == dev_id);
    assign w_rd_hit  = fx_rd && (fx_raddr[21:16] == dev_id);
    assign w_mask_wr = w_wr_hit && (fx_waddr[3:0] == c_reg_mask);
    assign w_ovf_wr  = w_wr_hit && (fx_waddr[3:0] == c_reg_ovf);

    rr_arb8 u_arb (
        .i_req     (r_pend & r_mask),
        .i_rr      (r_rr),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_grant = (r_state == ST_IDLE) && w_gnt_vld;

    always_comb begin
        w_gnt_oh = '0;
        if (w_grant) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
        end
    end

    // A fresh capture keeps the channel pending even while it is being granted;
    // a mask write clearing a bit drops that channel's pending sample outright.
    assign w_pend_nxt = ((r_pend & ~w_gnt_oh) | w_cap)
                      & (w_mask_wr ? fx_data : {NCH{1'b1}});
    assign w_ovf_nxt  = (w_ovf_wr ? (r_ovf & ~fx_data) : r_ovf)
                      | (w_cap & r_pend & ~w_gnt_oh);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_slot <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_cap[k]) begin
                    r_slot[k] <= ch_data[k*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_pend    <= '0;
            r_mask    <= '1;
            r_ovf     <= '0;
            r_rr      <= '0;
            r_seq     <= '0;
            r_pkt_cnt <= '0;
            r_data    <= '0;
            r_state   <= ST_IDLE;
            pkg_d     <= '0;
            pkg_vld   <= 1'b0;
            pkg_done  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ovf  <= w_ovf_nxt;
            if (w_mask_wr) begin
                r_mask <= fx_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_data   <= r_slot[w_gnt_idx];
                        r_rr     <= w_gnt_idx + 1'b1;
                        r_state  <= ST_HDR;
                        pkg_vld  <= 1'b1;
                        pkg_d    <= make_hdr(r_seq, w_gnt_idx);
                        pkg_done <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (pkg_rdy) begin
                        r_state  <= ST_DATA;
                        pkg_d    <= r_data;
                        pkg_done <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (pkg_rdy) begin
                        r_state   <= ST_IDLE;
                        pkg_vld   <= 1'b0;
                        pkg_done  <= 1'b0;
                        r_seq     <= r_seq + 1'b1;
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    pkg_vld  <= 1'b0;
                    pkg_done <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rd_val = 8'h00;
        case (fx_raddr[3:0])
            c_reg_mask:   w_rd_val = r_mask;
            c_reg_ovf:    w_rd_val = r_ovf;
            c_reg_pend:   w_rd_val = r_pend;
            c_reg_cnt_lo: w_rd_val = r_pkt_cnt[7:0];
            c_reg_cnt_hi: w_rd_val = r_pkt_cnt[15:8];
            c_reg_state:  w_rd_val = {6'b0, r_state};
            default:      w_rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fx_q <= 8'h00;
        end else begin
            fx_q <= w_rd_hit ? w_rd_val : 8'h00;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pkg_sched.sv
// ============================================================================
// Module  : tb_pkg_sched
// Brief   : Directed self-checking bench for pkg_sched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkg_sched;

    localparam logic [5:0] c_dev = 6'h2A;

    logic          clk_sys = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  ch_data = '0;
    logic [7:0]    ch_vld = '0;
    logic [15:0]   pkg_d;
    logic          pkg_vld;
    logic          pkg_rdy = 1'b1;
    logic          pkg_done;
    logic [21:0]   fx_waddr = '0;
    logic          fx_wr = 1'b0;
    logic [7:0]    fx_data = '0;
    logic [21:0]   fx_raddr = '0;
    logic          fx_rd = 1'b0;
    logic [7:0]    fx_q;
    logic [5:0]    dev_id = c_dev;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] r_rd;

    pkg_sched dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .ch_data  (ch_data),
        .ch_vld   (ch_vld),
        .pkg_d    (pkg_d),
        .pkg_vld  (pkg_vld),
        .pkg_rdy  (pkg_rdy),
        .pkg_done (pkg_done),
        .fx_waddr (fx_waddr),
        .fx_wr    (fx_wr),
        .fx_data  (fx_data),
        .fx_raddr (fx_raddr),
        .fx_rd    (fx_rd),
        .fx_q     (fx_q),
        .dev_id   (dev_id)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic strobe(input int ch, input logic [15:0] val);
        ch_data[ch*16 +: 16] = val;
        ch_vld = 8'h00;
        ch_vld[ch] = 1'b1;
        tick();
        ch_vld = 8'h00;
    endtask

    task automatic fx_write(input logic [3:0] reg_a, input logic [7:0] val);
        fx_waddr = {c_dev, 12'h000, reg_a};
        fx_data  = val;
        fx_wr    = 1'b1;
        tick();
        fx_wr    = 1'b0;
    endtask

    task automatic fx_read(input logic [3:0] reg_a, output logic [7:0] val);
        fx_raddr = {c_dev, 12'h000, reg_a};
        fx_rd    = 1'b1;
        tick();
        fx_rd    = 1'b0;
        val      = fx_q;
    endtask

    task automatic wait_vld();
        for (int n = 0; n < 20 && !pkg_vld; n++) tick();
        check("vld_wait", {31'b0, pkg_vld}, 32'd1);
    endtask

    // Assumes pkg_rdy=1: header word, then data word, then transfer of data.
    task automatic expect_pkt(input string tag, input logic [15:0] hdr, input logic [15:0] dat);
        wait_vld();
        check({tag, "_hdr"}, {16'b0, pkg_d}, {16'b0, hdr});
        check({tag, "_hdr_done"}, {31'b0, pkg_done}, 32'd0);
        tick();
        check({tag, "_dat"}, {16'b0, pkg_d}, {16'b0, dat});
        check({tag, "_dat_done"}, {31'b0, pkg_done}, 32'd1);
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_vld", {31'b0, pkg_vld}, 32'd0);
        check("rst_d", {16'b0, pkg_d}, 32'h0);
        check("rst_done", {31'b0, pkg_done}, 32'd0);
        fx_read(4'h0, r_rd); check("rst_mask", {24'b0, r_rd}, 32'hFF);
        fx_read(4'h2, r_rd); check("rst_pend", {24'b0, r_rd}, 32'h00);
        fx_read(4'h5, r_rd); check("rst_state", {24'b0, r_rd}, 32'h00);

        // 1) Single ch3 strobe, 2-cycle latency
        strobe(3, 16'h1234);
        check("t1_lat_c1", {31'b0, pkg_vld}, 32'd0);
        tick();
        check("t1_lat_c2", {31'b0, pkg_vld}, 32'd1);
        expect_pkt("t1", 16'hA503, 16'h1234);
        check("t1_idle", {31'b0, pkg_vld}, 32'd0);
        fx_read(4'h3, r_rd); check("t1_cnt_lo", {24'b0, r_rd}, 32'h01);
        fx_read(4'h4, r_rd); check("t1_cnt_hi", {24'b0, r_rd}, 32'h00);

        // 2) All channels at once from rr=0
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 8; k++) ch_data[k*16 +: 16] = 16'h1000 + 16'(k);
        ch_vld = 8'hFF; tick(); ch_vld = 8'h00;
        for (int k = 0; k < 8; k++) begin
            expect_pkt($sformatf("t2_ch%0d", k), 16'hA500 | 16'(k << 3) | 16'(k),
                       16'h1000 + 16'(k));
        end
        fx_read(4'h3, r_rd); check("t2_cnt", {24'b0, r_rd}, 32'h08);

        // 3) Backpressure on the header (seq=8, ch2)
        pkg_rdy = 1'b0;
        strobe(2, 16'h2222);
        wait_vld();
        for (int n = 0; n < 5; n++) begin
            check("t3_hold_vld", {31'b0, pkg_vld}, 32'd1);
            check("t3_hold_d", {16'b0, pkg_d}, 32'hA542);
            tick();
        end
        pkg_rdy = 1'b1;
        expect_pkt("t3", 16'hA542, 16'h2222);
        check("t3_no_dup", {31'b0, pkg_vld}, 32'd0);
        tick();
        check("t3_no_dup2", {31'b0, pkg_vld}, 32'd0);

        // 4) Overwrite of ch5 while the FSM is busy with ch1
        pkg_rdy = 1'b0;
        strobe(1, 16'h1111);
        wait_vld();
        strobe(5, 16'hAAAA);
        strobe(5, 16'hBBBB);
        pkg_rdy = 1'b1;
        expect_pkt("t4_ch1", 16'hA549, 16'h1111);
        expect_pkt("t4_ch5", 16'hA555, 16'hBBBB);
        fx_read(4'h1, r_rd); check("t4_ovf", {24'b0, r_rd}, 32'h20);
        fx_write(4'h1, 8'h20);
        fx_read(4'h1, r_rd); check("t4_ovf_clr", {24'b0, r_rd}, 32'h00);
        fx_read(4'h2, r_rd); check("t4_pend", {24'b0, r_rd}, 32'h00);

        // 5) Masked channel, mask-clears-pend, reset mid-DATA
        fx_write(4'h0, 8'hFE);
        strobe(0, 16'h0F0F);
        for (int n = 0; n < 4; n++) begin
            check("t5_masked_vld", {31'b0, pkg_vld}, 32'd0);
            tick();
        end
        fx_read(4'h2, r_rd); check("t5_masked_pend", {24'b0, r_rd}, 32'h00);
        fx_write(4'h0, 8'hFF);
        pkg_rdy = 1'b0;
        strobe(4, 16'h4444);
        wait_vld();
        pkg_rdy = 1'b1;
        tick();
        pkg_rdy = 1'b0;
        check("t5_in_data", {31'b0, pkg_done}, 32'd1);
        strobe(6, 16'h6666);
        fx_read(4'h2, r_rd); check("t5_pend6", {24'b0, r_rd}, 32'h40);
        fx_write(4'h0, 8'hBF);
        fx_read(4'h2, r_rd); check("t5_pend_clr", {24'b0, r_rd}, 32'h00);
        check("t5_still_data", {16'b0, pkg_d}, 32'h4444);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_rst_vld", {31'b0, pkg_vld}, 32'd0);
        check("t5_rst_done", {31'b0, pkg_done}, 32'd0);
        pkg_rdy = 1'b1;
        fx_read(4'h0, r_rd); check("t5_rst_mask", {24'b0, r_rd}, 32'hFF);

        // 6) seq wraps after 32 packets
        for (int i = 0; i < 33; i++) begin
            strobe(7, 16'h7000 + 16'(i));
            expect_pkt($sformatf("t6_p%0d", i), 16'hA500 | 16'((i % 32) << 3) | 16'h7,
                       16'h7000 + 16'(i));
        end
        fx_read(4'h3, r_rd); check("t6_cnt", {24'b0, r_rd}, 32'h21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
